// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared configuration for the writeback arbiter
package wb_arbiter_pkg;

  localparam int   XLEN_DEF           = 32;
  localparam int   XREG_ADDRWIDTH_DEF = 5;
  localparam int   STARVE_LIMIT_DEF   = 4;
  localparam logic RST_ENABLE         = 1'b1;
  localparam logic TRUE               = 1'b1;
  localparam logic FALSE              = 1'b0;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - pipeline/MDU writeback request and register file write bundle
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int XREG_ADDRWIDTH = XREG_ADDRWIDTH_DEF
) ();

  logic [XLEN-1:0]           pipe_rd;
  logic                      pipe_rd_en;
  logic [XREG_ADDRWIDTH-1:0] pipe_rd_addr;
  logic                      mdu_valid;
  logic [XLEN-1:0]           mdu_rd;
  logic [XREG_ADDRWIDTH-1:0] mdu_rd_addr;
  logic                      mdu_ready;
  logic                      stall_req;
  logic [XLEN-1:0]           wb_rd;
  logic                      wb_en;
  logic [XREG_ADDRWIDTH-1:0] wb_addr;

  modport slave (
    input  pipe_rd, pipe_rd_en, pipe_rd_addr,
    input  mdu_valid, mdu_rd, mdu_rd_addr,
    output mdu_ready, stall_req,
    output wb_rd, wb_en, wb_addr
  );

  modport master (
    output pipe_rd, pipe_rd_en, pipe_rd_addr,
    output mdu_valid, mdu_rd, mdu_rd_addr,
    input  mdu_ready, stall_req,
    input  wb_rd, wb_en, wb_addr
  );

endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register file write port arbiter between pipeline writeback and MDU
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int XREG_ADDRWIDTH = XREG_ADDRWIDTH_DEF,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);

  localparam logic [0:0] PIPE_PRI = 1'b0;
  localparam logic [0:0] MDU_PRI  = 1'b1;
  localparam int         CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [0:0]                state_q, state_d;
  logic [CNT_W-1:0]          starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0]          cnt_inc;
  logic [XLEN-1:0]           wb_rd_q, wb_rd_d;
  logic                      wb_en_q, wb_en_d;
  logic [XREG_ADDRWIDTH-1:0] wb_addr_q, wb_addr_d;
  logic                      pipe_req;
  logic                      mdu_ready;
  logic                      stall_req;
  logic                      mdu_xfer;
  logic                      mdu_denied;

  always_comb begin
    pipe_req = bus.pipe_rd_en && (bus.pipe_rd_addr != '0);
    mdu_ready = FALSE;
    stall_req = FALSE;
    // Handshake outputs are held low during reset so nothing transfers unregistered.
    if (rst != RST_ENABLE) begin
      if (state_q == MDU_PRI) begin
        mdu_ready = bus.mdu_valid;
        stall_req = bus.mdu_valid && pipe_req;
      end else begin
        mdu_ready = bus.mdu_valid && !pipe_req;
      end
    end
    mdu_xfer   = bus.mdu_valid && mdu_ready;
    mdu_denied = bus.mdu_valid && !mdu_ready;
  end

  always_comb begin
    cnt_inc = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;

    state_d = state_q;
    if (state_q == PIPE_PRI) begin
      if (mdu_denied && (cnt_inc == LIMIT)) begin
        state_d = MDU_PRI;
      end
    end else if (mdu_xfer || !bus.mdu_valid) begin
      state_d = PIPE_PRI;
    end

    starve_cnt_d = starve_cnt_q;
    if (mdu_xfer || !bus.mdu_valid) begin
      starve_cnt_d = '0;
    end else if (state_q == MDU_PRI && state_d == PIPE_PRI) begin
      starve_cnt_d = '0;
    end else if (mdu_denied) begin
      starve_cnt_d = cnt_inc;
    end
  end

  always_comb begin
    wb_en_d   = FALSE;
    wb_addr_d = '0;
    wb_rd_d   = '0;
    // An MDU result to x0 still completes its handshake but never writes.
    if (mdu_xfer && (bus.mdu_rd_addr != '0)) begin
      wb_en_d   = TRUE;
      wb_addr_d = bus.mdu_rd_addr;
      wb_rd_d   = bus.mdu_rd;
    end else if (pipe_req && !stall_req) begin
      wb_en_d   = TRUE;
      wb_addr_d = bus.pipe_rd_addr;
      wb_rd_d   = bus.pipe_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q      <= PIPE_PRI;
      starve_cnt_q <= '0;
      wb_en_q      <= FALSE;
      wb_addr_q    <= '0;
      wb_rd_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      wb_rd_q      <= wb_rd_d;
    end
  end

  assign bus.mdu_ready = mdu_ready;
  assign bus.stall_req = stall_req;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_arbiter_if #(.XLEN(32), .XREG_ADDRWIDTH(5)) bus ();

  wb_arbiter #(.XLEN(32), .XREG_ADDRWIDTH(5), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, check at the falling edge.
  // Expected wb_* reflect the write selected in the previous cycle.
  task automatic step(input string tag, input logic r,
                      input logic pen, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic e_rdy, input logic e_stall,
                      input logic e_en, input logic [4:0] e_addr, input logic [31:0] e_rd);
    @(posedge clk);
    #1;
    rst              = r;
    bus.pipe_rd_en   = pen;
    bus.pipe_rd_addr = pa;
    bus.pipe_rd      = pd;
    bus.mdu_valid    = mv;
    bus.mdu_rd_addr  = ma;
    bus.mdu_rd       = md;
    @(negedge clk);
    check({tag, ".mdu_ready"}, {31'd0, bus.mdu_ready}, {31'd0, e_rdy});
    check({tag, ".stall_req"}, {31'd0, bus.stall_req}, {31'd0, e_stall});
    check({tag, ".wb_en"}, {31'd0, bus.wb_en}, {31'd0, e_en});
    if (e_en) begin
      check({tag, ".wb_addr"}, {27'd0, bus.wb_addr}, {27'd0, e_addr});
      check({tag, ".wb_rd"}, bus.wb_rd, e_rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.pipe_rd_en = 1'b0; bus.pipe_rd_addr = '0; bus.pipe_rd = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd_addr = '0; bus.mdu_rd = '0;

    // Reset: handshake held low even with a valid MDU result pending
    step("rst0", 1, 0, 0, 0,      1, 5'd3, 32'h5, 0, 0, 0, 0, 0);
    check("rst0.wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    check("rst0.wb_rd", bus.wb_rd, 32'd0);
    step("rst1", 1, 1, 5'd2, 32'h9, 1, 5'd3, 32'h5, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0,      0, 0, 0,       0, 0, 0, 0, 0);

    // Pipe only
    step("p0", 0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
    step("p1", 0, 0, 0, 0,           0, 0, 0, 0, 0, 1, 5'd5, 32'h1234);
    step("p2", 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0);

    // MDU only
    step("m0", 0, 0, 0, 0, 1, 5'd7, 32'hDEAD, 1, 0, 0, 0, 0);
    step("m1", 0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 5'd7, 32'hDEAD);

    // Starvation: forced grant in cycle 4, held pipe entry written in cycle 6
    step("s0", 0, 1, 5'd10, 32'h100, 1, 5'd20, 32'hBEEF, 0, 0, 0, 0, 0);
    step("s1", 0, 1, 5'd11, 32'h101, 1, 5'd20, 32'hBEEF, 0, 0, 1, 5'd10, 32'h100);
    step("s2", 0, 1, 5'd12, 32'h102, 1, 5'd20, 32'hBEEF, 0, 0, 1, 5'd11, 32'h101);
    step("s3", 0, 1, 5'd13, 32'h103, 1, 5'd20, 32'hBEEF, 0, 0, 1, 5'd12, 32'h102);
    step("s4", 0, 1, 5'd14, 32'h104, 1, 5'd20, 32'hBEEF, 1, 1, 1, 5'd13, 32'h103);
    step("s5", 0, 1, 5'd14, 32'h104, 0, 0, 0,            0, 0, 1, 5'd20, 32'hBEEF);
    step("s6", 0, 1, 5'd15, 32'h105, 0, 0, 0,            0, 0, 1, 5'd14, 32'h104);
    step("s7", 0, 0, 0, 0,           0, 0, 0,            0, 0, 1, 5'd15, 32'h105);
    step("s8", 0, 0, 0, 0,           0, 0, 0,            0, 0, 0, 0, 0);

    // x0 handling
    step("x0", 0, 1, 5'd0, 32'h55, 1, 5'd9, 32'h99, 1, 0, 0, 0, 0);
    step("x1", 0, 0, 0, 0,         1, 5'd0, 32'h77, 1, 0, 1, 5'd9, 32'h99);
    step("x2", 0, 0, 0, 0,         0, 0, 0,         0, 0, 0, 0, 0);
    step("x3", 0, 0, 0, 0,         0, 0, 0,         0, 0, 0, 0, 0);

    // Reset while in MDU_PRI; MDU result re-contends from a cleared counter
    step("r0",  0, 1, 5'd1, 32'h11, 1, 5'd21, 32'hAAAA, 0, 0, 0, 0, 0);
    step("r1",  0, 1, 5'd2, 32'h12, 1, 5'd21, 32'hAAAA, 0, 0, 1, 5'd1, 32'h11);
    step("r2",  0, 1, 5'd3, 32'h13, 1, 5'd21, 32'hAAAA, 0, 0, 1, 5'd2, 32'h12);
    step("r3",  0, 1, 5'd4, 32'h14, 1, 5'd21, 32'hAAAA, 0, 0, 1, 5'd3, 32'h13);
    step("r4",  1, 1, 5'd5, 32'h15, 1, 5'd21, 32'hAAAA, 0, 0, 1, 5'd4, 32'h14);
    step("r5",  1, 1, 5'd5, 32'h15, 1, 5'd21, 32'hAAAA, 0, 0, 0, 0, 0);
    step("r6",  0, 1, 5'd5, 32'h15, 1, 5'd21, 32'hAAAA, 0, 0, 0, 0, 0);
    step("r7",  0, 1, 5'd6, 32'h16, 1, 5'd21, 32'hAAAA, 0, 0, 1, 5'd5, 32'h15);
    step("r8",  0, 1, 5'd7, 32'h17, 1, 5'd21, 32'hAAAA, 0, 0, 1, 5'd6, 32'h16);
    step("r9",  0, 1, 5'd8, 32'h18, 1, 5'd21, 32'hAAAA, 0, 0, 1, 5'd7, 32'h17);
    step("r10", 0, 1, 5'd9, 32'h19, 1, 5'd21, 32'hAAAA, 1, 1, 1, 5'd8, 32'h18);
    step("r11", 0, 1, 5'd9, 32'h19, 0, 0, 0,            0, 0, 1, 5'd21, 32'hAAAA);
    step("r12", 0, 0, 0, 0,         0, 0, 0,            0, 0, 1, 5'd9, 32'h19);
    step("r13", 0, 0, 0, 0,         0, 0, 0,            0, 0, 0, 0, 0);

    // Counter clears when mdu_valid drops; a fresh result waits the full 4 cycles
    step("c0",  0, 1, 5'd10, 32'h20, 1, 5'd22, 32'hBBBB, 0, 0, 0, 0, 0);
    step("c1",  0, 1, 5'd11, 32'h21, 1, 5'd22, 32'hBBBB, 0, 0, 1, 5'd10, 32'h20);
    step("c2",  0, 1, 5'd12, 32'h22, 0, 0, 0,            0, 0, 1, 5'd11, 32'h21);
    step("c3",  0, 1, 5'd13, 32'h23, 1, 5'd22, 32'hBBBB, 0, 0, 1, 5'd12, 32'h22);
    step("c4",  0, 1, 5'd14, 32'h24, 1, 5'd22, 32'hBBBB, 0, 0, 1, 5'd13, 32'h23);
    step("c5",  0, 1, 5'd15, 32'h25, 1, 5'd22, 32'hBBBB, 0, 0, 1, 5'd14, 32'h24);
    step("c6",  0, 1, 5'd16, 32'h26, 1, 5'd22, 32'hBBBB, 0, 0, 1, 5'd15, 32'h25);
    step("c7",  0, 1, 5'd17, 32'h27, 1, 5'd22, 32'hBBBB, 1, 1, 1, 5'd16, 32'h26);
    step("c8",  0, 1, 5'd17, 32'h27, 0, 0, 0,            0, 0, 1, 5'd22, 32'hBBBB);
    step("c9",  0, 0, 0, 0,          0, 0, 0,            0, 0, 1, 5'd17, 32'h27);
    step("c10", 0, 0, 0, 0,          0, 0, 0,            0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
